// File: rtl/radix5_input_buffer.sv
// Frame buffer feeding a radix-5 butterfly: stores 25 samples, replays them as five stride-5 lane groups.
// Latency 1 from the 25th accept to group 0; in_ready low while draining; lanes hold while out_ready is low.
module radix5_input_buffer #(
    parameter int DW     = 32,
    parameter int POINTS = 25,
    parameter int RADIX  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_img,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_re0,
    output logic [DW-1:0] out_re1,
    output logic [DW-1:0] out_re2,
    output logic [DW-1:0] out_re3,
    output logic [DW-1:0] out_re4,
    output logic [DW-1:0] out_img0,
    output logic [DW-1:0] out_img1,
    output logic [DW-1:0] out_img2,
    output logic [DW-1:0] out_img3,
    output logic [DW-1:0] out_img4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_group,
    output logic          out_last
);
    localparam int AW = $clog2(POINTS);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [2:0]    grp_q, grp_d;
    logic [DW-1:0] buf_re [POINTS];
    logic [DW-1:0] buf_im [POINTS];
    logic [DW-1:0] lane_re_q [RADIX];
    logic [DW-1:0] lane_re_d [RADIX];
    logic [DW-1:0] lane_im_q [RADIX];
    logic [DW-1:0] lane_im_d [RADIX];
    logic          in_acc, out_acc, load_en;
    logic [2:0]    load_grp;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && (grp_q == 3'(RADIX-1));
    assign out_group = grp_q;
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        grp_d    = grp_q;
        load_en  = 1'b0;
        load_grp = grp_q;
        case (state_q)
            FILL: begin
                if (in_acc) begin
                    if (wcnt_q == AW'(POINTS-1)) begin
                        // Group 0 never needs the sample written on this edge.
                        wcnt_d   = '0;
                        state_d  = DRAIN;
                        grp_d    = '0;
                        load_en  = 1'b1;
                        load_grp = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_acc) begin
                    if (grp_q == 3'(RADIX-1)) begin
                        state_d = FILL;
                        grp_d   = '0;
                    end else begin
                        grp_d    = grp_q + 1'b1;
                        load_en  = 1'b1;
                        load_grp = grp_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        for (int l = 0; l < RADIX; l++) begin
            lane_re_d[l] = lane_re_q[l];
            lane_im_d[l] = lane_im_q[l];
            if (load_en) begin
                lane_re_d[l] = buf_re[AW'(load_grp) + AW'(RADIX*l)];
                lane_im_d[l] = buf_im[AW'(load_grp) + AW'(RADIX*l)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_acc) begin
            buf_re[wcnt_q] <= in_re;
            buf_im[wcnt_q] <= in_img;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            grp_q   <= '0;
            for (int l = 0; l < RADIX; l++) begin
                lane_re_q[l] <= '0;
                lane_im_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            grp_q   <= grp_d;
            for (int l = 0; l < RADIX; l++) begin
                lane_re_q[l] <= lane_re_d[l];
                lane_im_q[l] <= lane_im_d[l];
            end
        end
    end

    assign out_re0  = lane_re_q[0];
    assign out_re1  = lane_re_q[1];
    assign out_re2  = lane_re_q[2];
    assign out_re3  = lane_re_q[3];
    assign out_re4  = lane_re_q[4];
    assign out_img0 = lane_im_q[0];
    assign out_img1 = lane_im_q[1];
    assign out_img2 = lane_im_q[2];
    assign out_img3 = lane_im_q[3];
    assign out_img4 = lane_im_q[4];
endmodule

// File: tb/tb_radix5_input_buffer.sv
// Directed bench for radix5_input_buffer: fill/drain, stalls, gapped input, mid-frame resets.
module tb_radix5_input_buffer;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_re, in_img;
    logic [31:0] ore [5];
    logic [31:0] oim [5];
    logic [2:0]  out_group;
    int          n_chk = 0;
    int          n_pass = 0;
    int          acc_cnt = 0;

    radix5_input_buffer dut (
        .clk(clk), .rst(rst),
        .in_re(in_re), .in_img(in_img), .in_valid(in_valid), .in_ready(in_ready),
        .out_re0(ore[0]), .out_re1(ore[1]), .out_re2(ore[2]), .out_re3(ore[3]), .out_re4(ore[4]),
        .out_img0(oim[0]), .out_img1(oim[1]), .out_img2(oim[2]), .out_img3(oim[3]), .out_img4(oim[4]),
        .out_valid(out_valid), .out_ready(out_ready), .out_group(out_group), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Sends n samples base..base+n-1; afterwards in_valid is left at 'hold'.
    task automatic fill(input int base, input bit gapped, input int n, input bit hold);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 200) begin
            in_valid = !(gapped && cyc[0]);
            in_re    = 32'(base + k);
            in_img   = 32'h100 + 32'(base + k);
            if (in_valid) chk("fill_rdy", {31'b0, in_ready}, 32'd1);
            step();
            if (in_valid) k++;
            cyc++;
        end
        chk("fill_done", k, n);
        in_valid = hold;
        in_re    = 32'hDEAD;
        in_img   = 32'hBEEF;
    endtask

    // Collects groups until stop_at handshakes; stall gives out_ready 1,0,0,1,0,0,...
    task automatic drain(input int base, input bit stall, input int stop_at);
        int g = 0;
        int cyc = 0;
        while (g < stop_at && cyc < 60) begin
            chk("dr_valid", {31'b0, out_valid}, 32'd1);
            chk("dr_inrdy", {31'b0, in_ready}, 32'd0);
            chk("dr_group", {29'b0, out_group}, 32'(g));
            chk("dr_last", {31'b0, out_last}, (g == 4) ? 32'd1 : 32'd0);
            for (int l = 0; l < 5; l++) begin
                chk("dr_re", ore[l], 32'(base + g + 5*l));
                chk("dr_img", oim[l], 32'h100 + 32'(base + g + 5*l));
            end
            out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            step();
            if (out_ready) g++;
            cyc++;
        end
        chk("dr_groups", g, stop_at);
        out_ready = 1'b0;
        if (stop_at == 5) begin
            chk("end_valid", {31'b0, out_valid}, 32'd0);
            chk("end_inrdy", {31'b0, in_ready}, 32'd1);
            chk("end_group", {29'b0, out_group}, 32'd0);
            chk("end_last", {31'b0, out_last}, 32'd0);
            chk("end_lane_hold", ore[4], 32'(base + 24));
            in_valid = 1'b0;
        end
    endtask

    initial begin
        int a0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_img = '0;
        step();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("rst_inrdy", {31'b0, in_ready}, 32'd1);
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_grp", {28'b0, out_last, out_group}, 32'd0);
            chk("rst_lanes", ore[0] | ore[1] | ore[2] | ore[3] | ore[4] |
                             oim[0] | oim[1] | oim[2] | oim[3] | oim[4], 32'd0);
            step();
        end

        // Continuous frame, no backpressure.
        a0 = acc_cnt;
        fill(0, 1'b0, 25, 1'b0);
        drain(0, 1'b0, 5);
        chk("acc_cont", acc_cnt - a0, 32'd25);

        // Stalled drain.
        a0 = acc_cnt;
        fill(0, 1'b0, 25, 1'b0);
        drain(0, 1'b1, 5);
        chk("acc_stall", acc_cnt - a0, 32'd25);

        // Gapped fill, in_valid held during drain.
        a0 = acc_cnt;
        fill(40, 1'b1, 25, 1'b1);
        drain(40, 1'b0, 5);
        chk("acc_gap", acc_cnt - a0, 32'd25);
        a0 = acc_cnt;
        fill(60, 1'b0, 25, 1'b0);
        drain(60, 1'b1, 5);
        chk("acc_after_hold", acc_cnt - a0, 32'd25);

        // Reset after 12 accepts, then a fresh frame.
        fill(200, 1'b0, 12, 1'b0);
        do_reset();
        chk("prst_inrdy", {31'b0, in_ready}, 32'd1);
        chk("prst_valid", {31'b0, out_valid}, 32'd0);
        fill(100, 1'b0, 25, 1'b0);
        drain(100, 1'b0, 5);

        // Reset while group 2 is stalled on the output.
        fill(300, 1'b0, 25, 1'b0);
        drain(300, 1'b0, 2);
        step();
        chk("stall_g2", {29'b0, out_group}, 32'd2);
        chk("stall_g2_re", ore[1], 32'd307);
        do_reset();
        chk("drst_valid", {31'b0, out_valid}, 32'd0);
        chk("drst_inrdy", {31'b0, in_ready}, 32'd1);
        chk("drst_group", {29'b0, out_group}, 32'd0);
        chk("drst_lanes", ore[0] | oim[4], 32'd0);
        fill(500, 1'b0, 25, 1'b0);
        drain(500, 1'b1, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
